key_schedule_ctrl: RTL and testbench

//   Sequential AES-128 key schedule controller. Accepts a cipher key over a valid/ready handshake.

---
 rtl/key_schedule_ctrl.sv | 165 ++++++++++++++++
 tb/tb_key_schedule_ctrl.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_ctrl.sv
// Sequential AES-128 key schedule controller.
// Accepts a cipher key over a valid/ready handshake and expands one round key per clock
// into an internal bank. Any bank entry can then be read back by index with one cycle of latency.
module key_schedule_ctrl #(
  parameter int unsigned NB   = 128,
  parameter int unsigned WORD = 32,
  parameter int unsigned NR   = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [NB-1:0] KeyIn,
  input  logic          KeyValid,
  output logic          KeyReady,
  input  logic [3:0]    ReadRound,
  output logic [NB-1:0] RoundKeyOut,
  output logic          Busy,
  output logic          Done
);

  typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

  // AES forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBox = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] subByte(input logic [7:0] b);
    return SBox[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    logic [7:0] r;
    r = 8'h00;
    case (n)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  state_e          stateQ, stateD;
  logic [3:0]      roundCntQ, roundCntD;
  logic [NB-1:0]   curKeyQ, curKeyD;
  logic [NB-1:0]   bankQ [0:NR];
  logic            bankWe;
  logic [3:0]      bankWAddr;
  logic [NB-1:0]   bankWData;

  // KeyExpansion interface
  logic [NB-1:0]   roundKey;
  logic [3:0]      roundNumber;
  logic [NB-1:0]   nextRoundKey;

  assign roundKey    = curKeyQ;
  assign roundNumber = roundCntQ;

  // One AES-128 KeyExpansion step: w3 rotated, substituted and Rcon-mixed, then chained XORs.
  always_comb begin
    logic [WORD-1:0] w0, w1, w2, w3, rot, temp, n0, n1, n2, n3;
    w0   = roundKey[NB-1        -: WORD];
    w1   = roundKey[NB-1-WORD   -: WORD];
    w2   = roundKey[NB-1-2*WORD -: WORD];
    w3   = roundKey[NB-1-3*WORD -: WORD];
    rot  = {w3[23:0], w3[31:24]};
    temp = {subByte(rot[31:24]) ^ rcon(roundNumber), subByte(rot[23:16]),
            subByte(rot[15:8]), subByte(rot[7:0])};
    n0   = w0 ^ temp;
    n1   = w1 ^ n0;
    n2   = w2 ^ n1;
    n3   = w3 ^ n2;
    nextRoundKey = {n0, n1, n2, n3};
  end

  // Next-state, bank write request and status outputs.
  always_comb begin
    stateD    = stateQ;
    roundCntD = roundCntQ;
    curKeyD   = curKeyQ;
    bankWe    = 1'b0;
    bankWAddr = 4'd0;
    bankWData = nextRoundKey;
    KeyReady  = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (stateQ)
      StIdle, StDone: begin
        KeyReady = 1'b1;
        Done     = (stateQ == StDone);
        if (KeyValid) begin
          bankWe    = 1'b1;
          bankWAddr = 4'd0;
          bankWData = KeyIn;
          curKeyD   = KeyIn;
          roundCntD = 4'd0;
          stateD    = StExpand;
        end
      end
      StExpand: begin
        Busy      = 1'b1;
        bankWe    = 1'b1;
        bankWAddr = roundCntQ + 4'd1;
        curKeyD   = nextRoundKey;
        if (roundCntQ == 4'(NR - 1)) begin
          roundCntD = 4'd0;
          stateD    = StDone;
        end else begin
          roundCntD = roundCntQ + 4'd1;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ    <= StIdle;
      roundCntQ <= 4'd0;
      curKeyQ   <= '0;
    end else begin
      stateQ    <= stateD;
      roundCntQ <= roundCntD;
      curKeyQ   <= curKeyD;
    end
  end

  // Round key bank; reset discards any partial schedule.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i <= NR; i++) begin
        bankQ[i] <= '0;
      end
    end else if (bankWe) begin
      bankQ[bankWAddr] <= bankWData;
    end
  end

  // Registered read port; sees pre-write contents when reading the entry written this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      RoundKeyOut <= '0;
    end else if (ReadRound <= 4'(NR)) begin
      RoundKeyOut <= bankQ[ReadRound];
    end else begin
      RoundKeyOut <= '0;
    end
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Self-checking bench for key_schedule_ctrl with a word-level AES key schedule model.
module tb_key_schedule_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] KeyIn;
  logic         KeyValid;
  logic         KeyReady;
  logic [3:0]   ReadRound;
  logic [127:0] RoundKeyOut;
  logic         Busy;
  logic         Done;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sboxM [0:255];
  logic [127:0] expSched [0:10];

  always #5 clk = ~clk;

  key_schedule_ctrl #(.NB(128), .WORD(32), .NR(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .KeyIn      (KeyIn),
    .KeyValid   (KeyValid),
    .KeyReady   (KeyReady),
    .ReadRound  (ReadRound),
    .RoundKeyOut(RoundKeyOut),
    .Busy       (Busy),
    .Done       (Done)
  );

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sboxM[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // FIPS-197 word recurrence over w[0..43].
  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sboxM[t[31:24]], sboxM[t[23:16]], sboxM[t[15:8]], sboxM[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = xtime(rc);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 11; r++) expSched[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic accept(input logic [127:0] key);
    KeyIn    = key;
    KeyValid = 1'b1;
    tick();
    KeyValid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    for (int n = 0; n < 30 && !Done; n++) tick();
    ok = Done;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    KeyValid  = 1'b0;
    KeyIn     = '0;
    ReadRound = 4'd0;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (KeyReady !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got ready=%b busy=%b done=%b, want 1 0 0", KeyReady, Busy, Done);
    end
    checks++;
    if (RoundKeyOut !== '0) begin
      errors++;
      $display("FAIL reset_out: got %h, want 0", RoundKeyOut);
    end
    for (int r = 0; r < 11; r++) begin
      ReadRound = 4'(r);
      tick();
      checks++;
      if (RoundKeyOut !== '0) begin
        errors++;
        $display("FAIL reset_bank[%0d]: got %h, want 0", r, RoundKeyOut);
      end
    end
  endtask

  task automatic test_fips();
    bit ok;
    model_expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    accept(128'h2b7e151628aed2a6abf7158809cf4f3c);
    wait_done(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL fips_done: got done=%b, want 1 within budget", Done);
    end
    ReadRound = 4'd1;
    tick();
    checks++;
    if (RoundKeyOut !== 128'ha0fafe1788542cb123a339392a6c7605) begin
      errors++;
      $display("FAIL fips_rk1: got %h, want a0fafe1788542cb123a339392a6c7605", RoundKeyOut);
    end
    ReadRound = 4'd10;
    tick();
    checks++;
    if (RoundKeyOut !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++;
      $display("FAIL fips_rk10: got %h, want d014f9a8c9ee2589e13f0cc8b6630ca6", RoundKeyOut);
    end
    for (int r = 0; r < 11; r++) begin
      ReadRound = 4'(r);
      tick();
      checks++;
      if (RoundKeyOut !== expSched[r]) begin
        errors++;
        $display("FAIL fips_bank[%0d]: got %h, want %h", r, RoundKeyOut, expSched[r]);
      end
    end
  endtask

  task automatic test_timing();
    logic [127:0] key;
    key = rand_key();
    model_expand(key);
    KeyIn    = key;
    KeyValid = 1'b1;
    checks++;
    if (KeyReady !== 1'b1) begin
      errors++;
      $display("FAIL timing_ready_before: got %b, want 1", KeyReady);
    end
    tick();
    KeyValid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (Busy !== 1'b1 || KeyReady !== 1'b0 || Done !== 1'b0) begin
        errors++;
        $display("FAIL timing_expand[E+%0d]: got busy=%b ready=%b done=%b, want 1 0 0",
                 k, Busy, KeyReady, Done);
      end
      tick();
    end
    checks++;
    if (Done !== 1'b1 || Busy !== 1'b0 || KeyReady !== 1'b1) begin
      errors++;
      $display("FAIL timing_done[E+10]: got done=%b busy=%b ready=%b, want 1 0 1",
               Done, Busy, KeyReady);
    end
    for (int r = 0; r < 11; r++) begin
      ReadRound = 4'(r);
      tick();
      checks++;
      if (RoundKeyOut !== expSched[r]) begin
        errors++;
        $display("FAIL timing_bank[%0d]: got %h, want %h", r, RoundKeyOut, expSched[r]);
      end
    end
  endtask

  task automatic test_ignore();
    logic [127:0] keyA;
    bit ok;
    keyA = rand_key();
    model_expand(keyA);
    accept(keyA);
    for (int k = 0; k < 9; k++) begin
      KeyIn    = rand_key();
      KeyValid = (k == 3) ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
    end
    KeyValid = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ignore_done: got done=%b, want 1 within budget", Done);
    end
    for (int r = 0; r < 11; r++) begin
      ReadRound = 4'(r);
      tick();
      checks++;
      if (RoundKeyOut !== expSched[r]) begin
        errors++;
        $display("FAIL ignore_bank[%0d]: got %h, want %h", r, RoundKeyOut, expSched[r]);
      end
    end
  endtask

  task automatic test_reload();
    logic [127:0] oldSched [0:10];
    bit ok;
    oldSched = expSched;
    model_expand(128'h000102030405060708090a0b0c0d0e0f);
    KeyIn     = 128'h000102030405060708090a0b0c0d0e0f;
    KeyValid  = 1'b1;
    ReadRound = 4'd0;
    tick();
    KeyValid = 1'b0;
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL reload_accept: got done=%b busy=%b, want 0 1", Done, Busy);
    end
    checks++;
    if (RoundKeyOut !== oldSched[0]) begin
      errors++;
      $display("FAIL reload_nobypass0: got %h, want %h", RoundKeyOut, oldSched[0]);
    end
    ReadRound = 4'd1;
    tick();
    checks++;
    if (RoundKeyOut !== oldSched[1]) begin
      errors++;
      $display("FAIL reload_nobypass1: got %h, want %h", RoundKeyOut, oldSched[1]);
    end
    ReadRound = 4'd10;
    tick();
    checks++;
    if (RoundKeyOut !== oldSched[10]) begin
      errors++;
      $display("FAIL reload_old10: got %h, want %h", RoundKeyOut, oldSched[10]);
    end
    ReadRound = 4'd0;
    tick();
    checks++;
    if (RoundKeyOut !== expSched[0]) begin
      errors++;
      $display("FAIL reload_new0: got %h, want %h", RoundKeyOut, expSched[0]);
    end
    wait_done(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reload_done: got done=%b, want 1 within budget", Done);
    end
    ReadRound = 4'd10;
    tick();
    checks++;
    if (RoundKeyOut !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
      errors++;
      $display("FAIL reload_rk10: got %h, want 13111d7fe3944a17f307a78b4d2b30c5", RoundKeyOut);
    end
  endtask

  task automatic test_out_of_range();
    for (int r = 11; r < 16; r++) begin
      ReadRound = 4'(r - 6);
      tick();
      ReadRound = 4'(r);
      tick();
      checks++;
      if (RoundKeyOut !== '0) begin
        errors++;
        $display("FAIL oor_read[%0d]: got %h, want 0", r, RoundKeyOut);
      end
    end
    ReadRound = 4'd0;
    tick();
    checks++;
    if (RoundKeyOut !== 128'h000102030405060708090a0b0c0d0e0f) begin
      errors++;
      $display("FAIL oor_read0: got %h, want 000102030405060708090a0b0c0d0e0f", RoundKeyOut);
    end
  endtask

  task automatic test_reset_mid();
    accept(rand_key());
    for (int k = 0; k < 4; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (KeyReady !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0 || RoundKeyOut !== '0) begin
      errors++;
      $display("FAIL midreset_status: got ready=%b busy=%b done=%b out=%h, want 1 0 0 0",
               KeyReady, Busy, Done, RoundKeyOut);
    end
    for (int r = 0; r < 11; r++) begin
      ReadRound = 4'(r);
      tick();
      checks++;
      if (RoundKeyOut !== '0) begin
        errors++;
        $display("FAIL midreset_bank[%0d]: got %h, want 0", r, RoundKeyOut);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] k1;
    logic [127:0] k2;
    bit ok;
    k1 = rand_key();
    k2 = rand_key();
    KeyIn    = k1;
    KeyValid = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) tick();
    checks++;
    if (Done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done_first: got %b, want 1", Done);
    end
    KeyIn = k2;
    tick();
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_reaccept: got done=%b busy=%b, want 0 1", Done, Busy);
    end
    wait_done(ok);
    KeyValid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_done_second: got done=%b, want 1 within budget", Done);
    end
    model_expand(k2);
    for (int r = 0; r < 11; r++) begin
      ReadRound = 4'(r);
      tick();
      checks++;
      if (RoundKeyOut !== expSched[r]) begin
        errors++;
        $display("FAIL b2b_bank[%0d]: got %h, want %h", r, RoundKeyOut, expSched[r]);
      end
    end
  endtask

  task automatic test_random();
    logic [127:0] key;
    logic [127:0] want;
    int r;
    bit ok;
    for (int it = 0; it < 4; it++) begin
      key = rand_key();
      model_expand(key);
      accept(key);
      wait_done(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL random_done[%0d]: got done=%b, want 1 within budget", it, Done);
      end
      for (int n = 0; n < 8; n++) begin
        r = int'($urandom_range(0, 15));
        ReadRound = 4'(r);
        tick();
        want = (r <= 10) ? expSched[r] : '0;
        checks++;
        if (RoundKeyOut !== want) begin
          errors++;
          $display("FAIL random_read[%0d]: idx=%0d got %h, want %h", it, r, RoundKeyOut, want);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_timing();
    test_ignore();
    test_reload();
    test_out_of_range();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
